// File: rtl/snake_body_engine.sv
// snake_body_engine
//   Snake body datapath. The body lives in a circular buffer addressed by a head
//   pointer and a length, so a move rewrites one entry instead of shifting the body.
//   Each move computes the next head, checks walls and self-collision, detects food,
//   erases the old tail and draws the new head through a ready/valid pixel port.
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_step, i_dir         move request pulse (taken only while o_ready) and direction
//   i_food_valid/x/y      live food cell
//   i_pix_ready           pixel sink accepts the pending pixel
//   o_pix_valid/x/y/col   pending pixel
//   o_ready, o_dead       idle / sticky collision flag
//   o_food_eaten          one-cycle pulse when a move eats food
//   o_length, o_head_x/y  body length and current head cell
module snake_body_engine #(
    parameter int unsigned COLS      = 52,
    parameter int unsigned ROWS      = 40,
    parameter int unsigned CELL      = 3,
    parameter int unsigned MAX_LEN   = 256,
    parameter int unsigned INIT_LEN  = 4,
    parameter int unsigned START_X   = 20,
    parameter int unsigned START_Y   = 20,
    parameter bit          WRAP      = 1'b1,
    parameter logic [2:0]  SNAKE_COL = 3'b010,
    localparam int unsigned CXW = $clog2(COLS),
    localparam int unsigned CYW = $clog2(ROWS),
    localparam int unsigned LW  = $clog2(MAX_LEN + 1)
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_step,
    input  logic [1:0]     i_dir,
    input  logic           i_food_valid,
    input  logic [CXW-1:0] i_food_x,
    input  logic [CYW-1:0] i_food_y,
    input  logic           i_pix_ready,
    output logic           o_pix_valid,
    output logic [7:0]     o_pix_x,
    output logic [6:0]     o_pix_y,
    output logic [2:0]     o_pix_col,
    output logic           o_ready,
    output logic           o_dead,
    output logic           o_food_eaten,
    output logic [LW-1:0]  o_length,
    output logic [CXW-1:0] o_head_x,
    output logic [CYW-1:0] o_head_y
);

    localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned OW = (CELL > 1) ? $clog2(CELL) : 1;
    localparam int unsigned EW = CXW + CYW;

    typedef enum logic [2:0] {
        StInit, StIdle, StCalc, StScan, StErase, StDraw, StCommit, StDead
    } state_e;

    state_e         r_state;
    logic [EW-1:0]  r_mem [MAX_LEN];
    logic [EW-1:0]  r_rd_data;
    logic [PW-1:0]  r_rd_addr;
    logic           r_rd_valid;
    logic [LW-1:0]  r_scan_left;
    logic [PW-1:0]  r_head_ptr;
    logic [CXW-1:0] r_head_x;
    logic [CYW-1:0] r_head_y;
    logic [LW-1:0]  r_length;
    logic [1:0]     r_cur_dir;
    logic [1:0]     r_new_dir;
    logic [CXW-1:0] r_nh_x;
    logic [CYW-1:0] r_nh_y;
    logic           r_grow;
    logic           r_eat;
    logic [LW-1:0]  r_init_idx;
    logic           r_pix_valid;
    logic [7:0]     r_pix_x;
    logic [6:0]     r_pix_y;
    logic [2:0]     r_pix_col;
    logic [OW-1:0]  r_ox;
    logic [OW-1:0]  r_oy;
    logic           r_ready;
    logic           r_dead;
    logic           r_food_eaten;

    logic [CXW-1:0] w_nh_x;
    logic [CYW-1:0] w_nh_y;
    logic           w_oob;
    logic           w_food_hit;
    logic           w_grow;
    logic           w_rev;
    logic           w_hs;
    logic           w_last;
    logic           w_load;
    logic [PW-1:0]  w_tail_addr;
    logic [CYW-1:0] w_init_y;
    logic [CXW-1:0] w_cell_x;
    logic [CYW-1:0] w_cell_y;
    logic [2:0]     w_cell_col;

    function automatic logic [7:0] f_base_x(input logic [CXW-1:0] cx);
        return 8'(32'(cx) * CELL);
    endfunction

    function automatic logic [6:0] f_base_y(input logic [CYW-1:0] cy);
        return 7'(32'(cy) * CELL);
    endfunction

    // Next head cell, with wrap values computed even when WRAP=0 (w_oob decides then).
    always_comb begin
        w_nh_x = r_head_x;
        w_nh_y = r_head_y;
        w_oob  = 1'b0;
        case (r_new_dir)
            2'b00: begin
                if (r_head_y == '0) begin
                    w_oob  = 1'b1;
                    w_nh_y = CYW'(ROWS - 1);
                end else begin
                    w_nh_y = r_head_y - CYW'(1);
                end
            end
            2'b01: begin
                if (r_head_y == CYW'(ROWS - 1)) begin
                    w_oob  = 1'b1;
                    w_nh_y = '0;
                end else begin
                    w_nh_y = r_head_y + CYW'(1);
                end
            end
            2'b10: begin
                if (r_head_x == '0) begin
                    w_oob  = 1'b1;
                    w_nh_x = CXW'(COLS - 1);
                end else begin
                    w_nh_x = r_head_x - CXW'(1);
                end
            end
            default: begin
                if (r_head_x == CXW'(COLS - 1)) begin
                    w_oob  = 1'b1;
                    w_nh_x = '0;
                end else begin
                    w_nh_x = r_head_x + CXW'(1);
                end
            end
        endcase
    end

    always_comb begin
        w_food_hit  = i_food_valid && (w_nh_x == i_food_x) && (w_nh_y == i_food_y);
        w_grow      = w_food_hit && (r_length < LW'(MAX_LEN));
        // Reverse pairs share bit 1 and differ in bit 0 (up/down, left/right).
        w_rev       = (i_dir[1] == r_cur_dir[1]) && (i_dir[0] != r_cur_dir[0]);
        w_hs        = r_pix_valid && i_pix_ready;
        w_last      = (r_ox == OW'(CELL - 1)) && (r_oy == OW'(CELL - 1));
        w_tail_addr = r_head_ptr + PW'(r_length - LW'(1));
        w_init_y    = CYW'(START_Y) + CYW'(r_init_idx);
        w_load      = !r_pix_valid &&
                      (r_state == StInit || r_state == StErase || r_state == StDraw);
        w_cell_x    = r_nh_x;
        w_cell_y    = r_nh_y;
        w_cell_col  = SNAKE_COL;
        case (r_state)
            StInit: begin
                w_cell_x = CXW'(START_X);
                w_cell_y = w_init_y;
            end
            StErase: begin
                // Tail entry was fetched on the last SCAN cycle.
                {w_cell_x, w_cell_y} = r_rd_data;
                w_cell_col           = 3'b000;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= StInit;
            r_rd_data    <= '0;
            r_rd_addr    <= '0;
            r_rd_valid   <= 1'b0;
            r_scan_left  <= '0;
            r_head_ptr   <= '0;
            r_head_x     <= CXW'(START_X);
            r_head_y     <= CYW'(START_Y);
            r_length     <= '0;
            r_cur_dir    <= 2'b00;
            r_new_dir    <= 2'b00;
            r_nh_x       <= '0;
            r_nh_y       <= '0;
            r_grow       <= 1'b0;
            r_eat        <= 1'b0;
            r_init_idx   <= '0;
            r_pix_valid  <= 1'b0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_col    <= '0;
            r_ox         <= '0;
            r_oy         <= '0;
            r_ready      <= 1'b0;
            r_dead       <= 1'b0;
            r_food_eaten <= 1'b0;
        end else begin
            r_food_eaten <= 1'b0;

            // Start a cell: pixel (0,0) of it becomes pending.
            if (w_load) begin
                r_pix_x     <= f_base_x(w_cell_x);
                r_pix_y     <= f_base_y(w_cell_y);
                r_pix_col   <= w_cell_col;
                r_ox        <= '0;
                r_oy        <= '0;
                r_pix_valid <= 1'b1;
            end

            // Row-major walk inside the cell; the last pixel is handled per state.
            if (w_hs && !w_last) begin
                if (r_ox == OW'(CELL - 1)) begin
                    r_ox    <= '0;
                    r_oy    <= r_oy + OW'(1);
                    r_pix_x <= r_pix_x - 8'(CELL - 1);
                    r_pix_y <= r_pix_y + 7'(1);
                end else begin
                    r_ox    <= r_ox + OW'(1);
                    r_pix_x <= r_pix_x + 8'(1);
                end
            end

            case (r_state)
                StInit: begin
                    if (w_load) begin
                        r_mem[PW'(r_init_idx)] <= {CXW'(START_X), w_init_y};
                    end else if (w_hs && w_last) begin
                        r_pix_valid <= 1'b0;
                        if (r_init_idx == LW'(INIT_LEN - 1)) begin
                            r_length <= LW'(INIT_LEN);
                            r_ready  <= 1'b1;
                            r_state  <= StIdle;
                        end else begin
                            r_init_idx <= r_init_idx + LW'(1);
                        end
                    end
                end
                StIdle: begin
                    if (i_step) begin
                        r_new_dir <= w_rev ? r_cur_dir : i_dir;
                        r_ready   <= 1'b0;
                        r_state   <= StCalc;
                    end
                end
                StCalc: begin
                    if (w_oob && !WRAP) begin
                        r_dead  <= 1'b1;
                        r_state <= StDead;
                    end else begin
                        r_nh_x      <= w_nh_x;
                        r_nh_y      <= w_nh_y;
                        r_grow      <= w_grow;
                        r_eat       <= w_food_hit;
                        // The old tail vacates on a plain move, so it is not scanned.
                        r_scan_left <= w_grow ? r_length : r_length - LW'(1);
                        r_rd_addr   <= r_head_ptr;
                        r_rd_valid  <= 1'b0;
                        r_state     <= StScan;
                    end
                end
                StScan: begin
                    if (r_rd_valid && (r_rd_data == {r_nh_x, r_nh_y})) begin
                        r_dead  <= 1'b1;
                        r_state <= StDead;
                    end else if (r_scan_left != '0) begin
                        r_rd_data   <= r_mem[r_rd_addr];
                        r_rd_addr   <= r_rd_addr + PW'(1);
                        r_scan_left <= r_scan_left - LW'(1);
                        r_rd_valid  <= 1'b1;
                    end else begin
                        r_rd_valid <= 1'b0;
                        r_rd_data  <= r_mem[w_tail_addr];
                        r_state    <= r_grow ? StDraw : StErase;
                    end
                end
                StErase: begin
                    if (w_hs && w_last) begin
                        r_pix_valid <= 1'b0;
                        r_state     <= StDraw;
                    end
                end
                StDraw: begin
                    if (w_hs && w_last) begin
                        r_pix_valid <= 1'b0;
                        r_state     <= StCommit;
                    end
                end
                StCommit: begin
                    r_head_ptr                   <= r_head_ptr - PW'(1);
                    r_mem[r_head_ptr - PW'(1)]   <= {r_nh_x, r_nh_y};
                    r_head_x                     <= r_nh_x;
                    r_head_y                     <= r_nh_y;
                    r_length                     <= r_length + LW'(r_grow);
                    r_cur_dir                    <= r_new_dir;
                    r_food_eaten                 <= r_eat;
                    r_ready                      <= 1'b1;
                    r_state                      <= StIdle;
                end
                StDead: begin
                    r_pix_valid <= 1'b0;
                    r_ready     <= 1'b0;
                end
                default: r_state <= StDead;
            endcase
        end
    end

    assign o_pix_valid  = r_pix_valid;
    assign o_pix_x      = r_pix_x;
    assign o_pix_y      = r_pix_y;
    assign o_pix_col    = r_pix_col;
    assign o_ready      = r_ready;
    assign o_dead       = r_dead;
    assign o_food_eaten = r_food_eaten;
    assign o_length     = r_length;
    assign o_head_x     = r_head_x;
    assign o_head_y     = r_head_y;

endmodule

// File: tb/tb_snake_body_engine.sv
// tb_snake_body_engine
//   Directed bench for snake_body_engine: a wrapping instance with the default
//   start position and a non-wrapping instance placed on the left wall.
module tb_snake_body_engine;

    logic       clk;
    logic       rst;
    logic       step;
    logic [1:0] dir;
    logic       food_valid;
    logic [5:0] food_x;
    logic [5:0] food_y;
    logic       pix_ready;
    logic       pix_valid;
    logic [7:0] pix_x;
    logic [6:0] pix_y;
    logic [2:0] pix_col;
    logic       ready;
    logic       dead;
    logic       food_eaten;
    logic [8:0] length;
    logic [5:0] head_x;
    logic [5:0] head_y;

    logic       step2;
    logic [1:0] dir2;
    logic       food_valid2;
    logic [5:0] food_x2;
    logic [5:0] food_y2;
    logic       pix_ready2;
    logic       pix_valid2;
    logic [7:0] pix_x2;
    logic [6:0] pix_y2;
    logic [2:0] pix_col2;
    logic       ready2;
    logic       dead2;
    logic       food_eaten2;
    logic [8:0] length2;
    logic [5:0] head_x2;
    logic [5:0] head_y2;

    int          checks;
    int          failures;
    logic [17:0] px_q[$];
    int          fe_cnt;
    int          fe2_cnt;
    int          pix2_cnt;
    logic [17:0] pix2_first;
    logic        stall_prev;
    logic [17:0] stall_val;

    snake_body_engine u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_step       (step),
        .i_dir        (dir),
        .i_food_valid (food_valid),
        .i_food_x     (food_x),
        .i_food_y     (food_y),
        .i_pix_ready  (pix_ready),
        .o_pix_valid  (pix_valid),
        .o_pix_x      (pix_x),
        .o_pix_y      (pix_y),
        .o_pix_col    (pix_col),
        .o_ready      (ready),
        .o_dead       (dead),
        .o_food_eaten (food_eaten),
        .o_length     (length),
        .o_head_x     (head_x),
        .o_head_y     (head_y)
    );

    snake_body_engine #(
        .START_X (0),
        .START_Y (5),
        .WRAP    (1'b0)
    ) u_wall (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_step       (step2),
        .i_dir        (dir2),
        .i_food_valid (food_valid2),
        .i_food_x     (food_x2),
        .i_food_y     (food_y2),
        .i_pix_ready  (pix_ready2),
        .o_pix_valid  (pix_valid2),
        .o_pix_x      (pix_x2),
        .o_pix_y      (pix_y2),
        .o_pix_col    (pix_col2),
        .o_ready      (ready2),
        .o_dead       (dead2),
        .o_food_eaten (food_eaten2),
        .o_length     (length2),
        .o_head_x     (head_x2),
        .o_head_y     (head_y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected pixel k (row-major) of cell (cx,cy) with CELL=3.
    function automatic logic [17:0] f_pix(input int cx, input int cy, input int k,
                                          input logic [2:0] col);
        int x;
        int y;
        x = cx * 3 + k % 3;
        y = cy * 3 + k / 3;
        return {8'(x), 7'(y), col};
    endfunction

    // Observation on the falling edge, away from the DUT's active edge.
    always @(negedge clk) begin
        if (stall_prev) begin
            checks++;
            if (!pix_valid || {pix_x, pix_y, pix_col} !== stall_val) begin
                failures++;
                $display("FAIL pix_stable got=%0b/%h want=1/%h", pix_valid,
                         {pix_x, pix_y, pix_col}, stall_val);
            end
        end
        stall_prev = pix_valid && !pix_ready && !rst;
        stall_val  = {pix_x, pix_y, pix_col};
        if (pix_valid && pix_ready && !rst) px_q.push_back({pix_x, pix_y, pix_col});
        if (food_eaten) fe_cnt++;
        if (food_eaten2) fe2_cnt++;
        if (pix_valid2 && pix_ready2 && !rst) begin
            if (pix2_cnt == 0) pix2_first = {pix_x2, pix_y2, pix_col2};
            pix2_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (!ready && !dead && n < 5000) begin
            tick();
            n++;
        end
        ok = ready || dead;
    endtask

    task automatic do_step(input logic [1:0] d, input bit rnd, output bit ok);
        int n;
        wait_ready(ok);
        dir  = d;
        step = 1'b1;
        tick();
        step = 1'b0;
        n    = 0;
        while (!ready && !dead && n < 5000) begin
            if (rnd) pix_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        pix_ready = 1'b1;
        ok = ok && (ready || dead);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tick();
        checks++;
        if ({pix_valid, ready, dead, food_eaten} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got=%b want=0000", {pix_valid, ready, dead, food_eaten});
        end
        checks++;
        if (length !== 9'd0) begin
            failures++;
            $display("FAIL reset_length got=%0d want=0", length);
        end
        checks++;
        if (head_x !== 6'd20 || head_y !== 6'd20) begin
            failures++;
            $display("FAIL reset_head got=(%0d,%0d) want=(20,20)", head_x, head_y);
        end
    endtask

    task automatic test_init();
        bit          ok;
        logic [17:0] got;
        px_q.delete();
        rst = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok || ready !== 1'b1) begin
            failures++;
            $display("FAIL init_ready got=%b want=1", ready);
        end
        checks++;
        if (px_q.size() != 36) begin
            failures++;
            $display("FAIL init_pix_count got=%0d want=36", px_q.size());
        end
        for (int k = 0; k < 36; k++) begin
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== f_pix(20, 20 + k / 9, k % 9, 3'b010)) begin
                failures++;
                $display("FAIL init_pix[%0d] got=%h want=%h", k, got,
                         f_pix(20, 20 + k / 9, k % 9, 3'b010));
            end
        end
        checks++;
        if (length !== 9'd4 || head_x !== 6'd20 || head_y !== 6'd20) begin
            failures++;
            $display("FAIL init_state got=len%0d (%0d,%0d) want=len4 (20,20)", length, head_x,
                     head_y);
        end
    endtask

    task automatic test_move();
        bit          ok;
        logic [17:0] got;
        logic [17:0] exp;
        px_q.delete();
        fe_cnt = 0;
        do_step(2'b11, 1'b0, ok);
        checks++;
        if (!ok || head_x !== 6'd21 || head_y !== 6'd20) begin
            failures++;
            $display("FAIL move_head got=(%0d,%0d) want=(21,20)", head_x, head_y);
        end
        checks++;
        if (length !== 9'd4 || fe_cnt != 0) begin
            failures++;
            $display("FAIL move_len got=len%0d eaten%0d want=len4 eaten0", length, fe_cnt);
        end
        checks++;
        if (px_q.size() != 18) begin
            failures++;
            $display("FAIL move_pix_count got=%0d want=18", px_q.size());
        end
        for (int k = 0; k < 18; k++) begin
            exp = (k < 9) ? f_pix(20, 23, k, 3'b000) : f_pix(21, 20, k - 9, 3'b010);
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL move_pix[%0d] got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_food();
        bit          ok;
        logic [17:0] got;
        px_q.delete();
        fe_cnt     = 0;
        food_valid = 1'b1;
        food_x     = 6'd21;
        food_y     = 6'd19;
        do_step(2'b00, 1'b0, ok);
        food_valid = 1'b0;
        tick();
        checks++;
        if (!ok || fe_cnt != 1) begin
            failures++;
            $display("FAIL food_pulse got=%0d want=1", fe_cnt);
        end
        checks++;
        if (length !== 9'd5 || head_x !== 6'd21 || head_y !== 6'd19) begin
            failures++;
            $display("FAIL food_state got=len%0d (%0d,%0d) want=len5 (21,19)", length, head_x,
                     head_y);
        end
        checks++;
        if (px_q.size() != 9) begin
            failures++;
            $display("FAIL food_pix_count got=%0d want=9", px_q.size());
        end
        for (int k = 0; k < 9; k++) begin
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== f_pix(21, 19, k, 3'b010)) begin
                failures++;
                $display("FAIL food_pix[%0d] got=%h want=%h", k, got, f_pix(21, 19, k, 3'b010));
            end
        end
    endtask

    task automatic test_wrap();
        bit          ok;
        bit          all_ok;
        logic [17:0] got;
        logic [17:0] exp;
        all_ok = 1'b1;
        for (int i = 0; i < 21; i++) begin
            do_step(2'b10, 1'b0, ok);
            all_ok &= ok;
        end
        for (int i = 0; i < 14; i++) begin
            do_step(2'b00, 1'b0, ok);
            all_ok &= ok;
        end
        checks++;
        if (!all_ok || dead !== 1'b0 || head_x !== 6'd0 || head_y !== 6'd5) begin
            failures++;
            $display("FAIL wrap_path got=(%0d,%0d) dead%b want=(0,5) dead0", head_x, head_y, dead);
        end
        px_q.delete();
        do_step(2'b10, 1'b0, ok);
        checks++;
        if (!ok || dead !== 1'b0 || head_x !== 6'd51 || head_y !== 6'd5) begin
            failures++;
            $display("FAIL wrap_head got=(%0d,%0d) dead%b want=(51,5) dead0", head_x, head_y,
                     dead);
        end
        for (int k = 0; k < 18; k++) begin
            exp = (k < 9) ? f_pix(0, 9, k, 3'b000) : f_pix(51, 5, k - 9, 3'b010);
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL wrap_pix[%0d] got=%h want=%h", k, got, exp);
            end
        end
    endtask

    task automatic test_wall();
        int n;
        int snap;
        n = 0;
        while (!ready2 && n < 5000) begin
            tick();
            n++;
        end
        checks++;
        if (ready2 !== 1'b1 || pix2_cnt != 36 || pix2_first !== f_pix(0, 5, 0, 3'b010)) begin
            failures++;
            $display("FAIL wall_init got=rdy%b n%0d first%h want=rdy1 n36 first%h", ready2,
                     pix2_cnt, pix2_first, f_pix(0, 5, 0, 3'b010));
        end
        snap  = pix2_cnt;
        dir2  = 2'b10;
        step2 = 1'b1;
        tick();
        step2 = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        checks++;
        if (dead2 !== 1'b1 || ready2 !== 1'b0) begin
            failures++;
            $display("FAIL wall_dead got=dead%b rdy%b want=dead1 rdy0", dead2, ready2);
        end
        checks++;
        if (pix2_cnt != snap || head_x2 !== 6'd0 || head_y2 !== 6'd5 || length2 !== 9'd4 ||
            fe2_cnt != 0) begin
            failures++;
            $display("FAIL wall_quiet got=pix%0d (%0d,%0d) len%0d want=pix%0d (0,5) len4",
                     pix2_cnt - snap, head_x2, head_y2, length2, 0);
        end
    endtask

    task automatic test_reverse_and_self();
        bit ok;
        do_step(2'b00, 1'b0, ok);
        do_step(2'b01, 1'b0, ok);
        checks++;
        if (!ok || dead !== 1'b0 || head_x !== 6'd51 || head_y !== 6'd3) begin
            failures++;
            $display("FAIL reverse_head got=(%0d,%0d) dead%b want=(51,3) dead0", head_x, head_y,
                     dead);
        end
        do_step(2'b10, 1'b0, ok);
        do_step(2'b01, 1'b0, ok);
        px_q.delete();
        do_step(2'b11, 1'b0, ok);
        checks++;
        if (!ok || dead !== 1'b1 || ready !== 1'b0) begin
            failures++;
            $display("FAIL self_dead got=dead%b rdy%b want=dead1 rdy0", dead, ready);
        end
        checks++;
        if (px_q.size() != 0 || head_x !== 6'd50 || head_y !== 6'd4) begin
            failures++;
            $display("FAIL self_quiet got=pix%0d (%0d,%0d) want=pix0 (50,4)", px_q.size(),
                     head_x, head_y);
        end
        dir  = 2'b00;
        step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 30; i++) tick();
        checks++;
        if (dead !== 1'b1 || px_q.size() != 0 || head_x !== 6'd50 || head_y !== 6'd4) begin
            failures++;
            $display("FAIL dead_sticky got=dead%b pix%0d (%0d,%0d) want=dead1 pix0 (50,4)", dead,
                     px_q.size(), head_x, head_y);
        end
    endtask

    task automatic test_backpressure();
        bit          ok;
        int          n;
        logic [17:0] got;
        logic [17:0] exp;
        rst = 1'b1;
        tick();
        tick();
        px_q.delete();
        rst = 1'b0;
        wait_ready(ok);
        px_q.delete();
        do_step(2'b11, 1'b1, ok);
        checks++;
        if (!ok || px_q.size() != 18 || head_x !== 6'd21 || head_y !== 6'd20) begin
            failures++;
            $display("FAIL bp_move got=pix%0d (%0d,%0d) want=pix18 (21,20)", px_q.size(),
                     head_x, head_y);
        end
        for (int k = 0; k < 18; k++) begin
            exp = (k < 9) ? f_pix(20, 23, k, 3'b000) : f_pix(21, 20, k - 9, 3'b010);
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== exp) begin
                failures++;
                $display("FAIL bp_pix[%0d] got=%h want=%h", k, got, exp);
            end
        end
        // Second move: reset once the new head cell is partly drawn.
        px_q.delete();
        dir  = 2'b00;
        step = 1'b1;
        tick();
        step = 1'b0;
        n    = 0;
        while (px_q.size() < 12 && n < 2000) begin
            pix_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        checks++;
        if (px_q.size() < 12) begin
            failures++;
            $display("FAIL bp_mid_draw got=%0d want>=12", px_q.size());
        end
        rst       = 1'b1;
        pix_ready = 1'b1;
        tick();
        tick();
        px_q.delete();
        rst = 1'b0;
        wait_ready(ok);
        checks++;
        if (!ok || px_q.size() != 36 || length !== 9'd4 || head_x !== 6'd20 ||
            head_y !== 6'd20 || dead !== 1'b0) begin
            failures++;
            $display("FAIL rst_restart got=pix%0d len%0d (%0d,%0d) want=pix36 len4 (20,20)",
                     px_q.size(), length, head_x, head_y);
        end
        for (int k = 0; k < 36; k++) begin
            got = (k < px_q.size()) ? px_q[k] : 'x;
            checks++;
            if (got !== f_pix(20, 20 + k / 9, k % 9, 3'b010)) begin
                failures++;
                $display("FAIL rst_pix[%0d] got=%h want=%h", k, got,
                         f_pix(20, 20 + k / 9, k % 9, 3'b010));
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        fe_cnt      = 0;
        fe2_cnt     = 0;
        pix2_cnt    = 0;
        pix2_first  = '0;
        stall_prev  = 1'b0;
        stall_val   = '0;
        rst         = 1'b1;
        step        = 1'b0;
        dir         = 2'b00;
        food_valid  = 1'b0;
        food_x      = '0;
        food_y      = '0;
        pix_ready   = 1'b1;
        step2       = 1'b0;
        dir2        = 2'b00;
        food_valid2 = 1'b0;
        food_x2     = '0;
        food_y2     = '0;
        pix_ready2  = 1'b1;

        test_reset();
        test_init();
        test_move();
        test_food();
        test_wrap();
        test_wall();
        test_reverse_and_self();
        test_backpressure();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
